dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory slave that answers the memory stage's load/store requests: request, we_re, mask, address and store data in; load data and data_valid out.
- Holds a word-organised, byte-lane-writable RAM.
- Completes each access after a fixed, parameterised latency and returns one data_valid pulse per access, which the core uses as its stall release.
- Sits between the memory stage and the data RAM, in place of an ideal zero-latency memory.

Parameters:
- DataWidth, 32: data bus width; fixed at 32 for RV32I.
- AddrWidth, 10: word-index width; RAM depth is 2**AddrWidth words.
- Latency, 2: cycles from the accepting edge to data_valid high; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- request  input  1  access request from the memory stage
- we_re  input  1  1 = store, 0 = load; valid while request is high
- mask  input  4  byte-lane enables, already lane-aligned by the initiator
- address  input  32  byte address; bits [AddrWidth+1:2] select the word
- store_data  input  32  lane-aligned store data
- load_data  output  32  full 32-bit read word; the initiator extracts lanes
- data_valid  output  1  one-cycle completion pulse for both loads and stores
- busy  output  1  high while an access is in flight, including the RESP cycle

Behaviour:
- FSM states: IDLE, BUSY, RESP. Latency counter width is $clog2(16).
- Reset (rst low, async): state becomes IDLE, counter 0, data_valid 0, load_data 0, busy 0. RAM contents are not cleared.
- IDLE: a rising edge with request=1 accepts the access. At that same edge:
  - index = address[AddrWidth+1:2]; address bits [1:0] and the bits above AddrWidth+1 are ignored, so addresses alias.
  - Store: lanes with mask[i]=1 are written from store_data[8i+7:8i]. mask=0 writes nothing but is still acknowledged.
  - Load: the word at index is captured into a read register (read-before-write is irrelevant; one access at a time).
  - Counter is loaded with Latency-1.
  - Next state is RESP if Latency==1, otherwise BUSY.
- BUSY: counter decrements each cycle; moves to RESP when the counter reaches 1. request and all other inputs are ignored.
- RESP: data_valid=1 for exactly this one cycle.
  - load_data presents the captured word (loads) or holds its previous value (stores).
  - request seen in RESP is not accepted: the initiator still holds request for the completed access. Next state is IDLE.
- Timing: accept at edge k, data_valid high in the cycle after edge k+Latency-1. Minimum spacing between accepts is Latency+1 cycles.
- load_data holds its value until the next load completes.
- busy = (state != IDLE).
- A reset asserted while in BUSY or RESP aborts the access with no data_valid. A store already performed at the accepting edge is not undone.
- X-safety: we_re, mask and address are sampled only at the accepting edge.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output access_err (1 bit, reset 0).
  - An address with any nonzero bit above AddrWidth+1 is out of range: the store is suppressed, load_data is forced to 0, and access_err pulses high in the same cycle as data_valid.
  - Aliasing is disabled.
- Undefined: no access_err port; upper address bits are ignored and addresses alias.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] dmem_state_e {IDLE, BUSY, RESP}
  - localparam LAT_CNT_W = 4
  - localparam BYTES_PER_WORD = 4
- Sub-module dmem_bank: single-port RAM array with clocked write under a 4-bit byte-write enable and a combinational read by index. dmem_responder instantiates it once and owns the FSM, counter and output registers.

Test Plan:
1. Reset values: hold rst low with request=1 -> data_valid=0, busy=0, load_data=0; after release with request=0 -> stays IDLE.
2. Store then load, Latency=2: store 0xDEADBEEF to 0x10 with mask 1111 -> data_valid pulses exactly at accept+2. Then load 0x10 -> data_valid at accept+2 with load_data=0xDEADBEEF.
3. Partial store: mask 0010, store_data 0x0000AB00 to 0x10, then load -> 0xDEADABEF. Store with mask 0000 -> acknowledged, word unchanged.
4. Held request: request kept high for 6 cycles on one load -> exactly one data_valid; second accept occurs at the IDLE edge following RESP; busy high from accept through RESP.
5. Aliasing (macro off): store 0x11223344 to 0x1010 -> load 0x10 returns 0x11223344. With DMEM_RANGE_CHECK_EN: the same store gives access_err=1 with data_valid and word 0x10 unchanged.
6. Reset mid-BUSY with Latency=4: assert rst 2 cycles after accept -> no data_valid, state IDLE. A fresh load afterwards completes normally and reflects the earlier store.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_e;

  // Wide enough for any latency in 1..15
  localparam int LAT_CNT_W      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM with per-byte write enables and a combinational read.
// Contents are deliberately not reset.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
) (
  input  logic                      clk,
  input  logic [BYTES_PER_WORD-1:0] we,
  input  logic [AddrWidth-1:0]      idx,
  input  logic [DataWidth-1:0]      wdata,
  output logic [DataWidth-1:0]      rdata
);

  localparam int LaneW = DataWidth / BYTES_PER_WORD;

  logic [DataWidth-1:0] mem [2**AddrWidth];

  // Byte-lane write; only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (we[i]) mem[idx][LaneW*i +: LaneW] <= wdata[LaneW*i +: LaneW];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the memory stage: accepts one load/store at a time,
// completes it after a fixed Latency and pulses data_valid once per access.
// Optional build macro DMEM_RANGE_CHECK_EN adds access_err and rejects
// addresses with nonzero bits above the RAM index instead of aliasing them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10,
  parameter int Latency   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      request,
  input  logic                      we_re,
  input  logic [BYTES_PER_WORD-1:0] mask,
  input  logic [31:0]               address,
  input  logic [DataWidth-1:0]      store_data,
  output logic [DataWidth-1:0]      load_data,
  output logic                      data_valid,
  output logic                      busy
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic                      access_err
`endif
);

  dmem_state_e          state;
  logic [LAT_CNT_W-1:0] cnt;

  logic                      accept;
  logic                      oor;
  logic                      live_upd;
  logic [AddrWidth-1:0]      idx;
  logic [BYTES_PER_WORD-1:0] bank_we;
  logic [DataWidth-1:0]      bank_rdata;
  logic [DataWidth-1:0]      live_word;

  // Completion data captured at the accepting edge
  logic [DataWidth-1:0] rd_word_p1;
  logic                 upd_p1;

  assign idx = address[AddrWidth+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  logic err_p1;
  logic unused_addr_lsb;
  assign oor             = |address[31:AddrWidth+2];
  assign unused_addr_lsb = ^address[1:0];
`else
  logic unused_addr_bits;
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{address[31:AddrWidth+2], address[1:0]};
`endif

  assign accept    = (state == IDLE) && request;
  assign bank_we   = (accept && we_re && !oor) ? mask : '0;
  // Out-of-range accesses return zero; stores otherwise leave load_data alone
  assign live_word = oor ? '0 : bank_rdata;
  assign live_upd  = !we_re || oor;
  assign busy      = (state != IDLE);

  dmem_bank #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .idx  (idx),
    .wdata(store_data),
    .rdata(bank_rdata)
  );

  // Stage p1: capture the read word and completion kind at the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_p1 <= live_word;
      upd_p1     <= live_upd;
`ifdef DMEM_RANGE_CHECK_EN
      err_p1     <= oor;
`endif
    end
  end

  // Access FSM: latency countdown and registered completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_valid <= 1'b0;
      load_data  <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      access_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      access_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= LAT_CNT_W'(Latency - 1);
            if (Latency == 1) begin
              // Single-cycle latency completes straight from live values
              state      <= RESP;
              data_valid <= 1'b1;
              if (live_upd) load_data <= live_word;
`ifdef DMEM_RANGE_CHECK_EN
              access_err <= oor;
`endif
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - LAT_CNT_W'(1);
          if (cnt <= LAT_CNT_W'(1)) begin
            state      <= RESP;
            data_valid <= 1'b1;
            if (upd_p1) load_data <= rd_word_p1;
`ifdef DMEM_RANGE_CHECK_EN
            access_err <= err_p1;
`endif
          end
        end
        // Request still held here belongs to the finished access; not accepted
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a Latency=2 instance for the main
// function and a Latency=4 instance for the reset-abort sequence.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 (Latency 2)
  logic        rst0 = 1'b1, req0 = 1'b0, we0 = 1'b0;
  logic [3:0]  msk0 = '0;
  logic [31:0] adr0 = '0, sd0 = '0, ld0;
  logic        dv0, bsy0;
  // Instance 1 (Latency 4)
  logic        rst1 = 1'b1, req1 = 1'b0, we1 = 1'b0;
  logic [3:0]  msk1 = '0;
  logic [31:0] adr1 = '0, sd1 = '0, ld1;
  logic        dv1, bsy1;

  dmem_responder #(.DataWidth(32), .AddrWidth(10), .Latency(2)) dut (
    .clk(clk), .rst(rst0), .request(req0), .we_re(we0), .mask(msk0),
    .address(adr0), .store_data(sd0), .load_data(ld0), .data_valid(dv0),
    .busy(bsy0));

  dmem_responder #(.DataWidth(32), .AddrWidth(10), .Latency(4)) dut4 (
    .clk(clk), .rst(rst1), .request(req1), .we_re(we1), .mask(msk1),
    .address(adr1), .store_data(sd1), .load_data(ld1), .data_valid(dv1),
    .busy(bsy1));

  int errors = 0;
  int checks = 0;

  // Reference memory: key = instance*4096 + word index
  logic [31:0] mdl [int];

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int key_of(int d, logic [31:0] a);
    return d * 4096 + int'((a / 32'd4) % 32'd1024);
  endfunction

  function automatic logic get_dv(int d);
    return (d == 0) ? dv0 : dv1;
  endfunction

  function automatic logic get_bsy(int d);
    return (d == 0) ? bsy0 : bsy1;
  endfunction

  function automatic logic [31:0] get_ld(int d);
    return (d == 0) ? ld0 : ld1;
  endfunction

  task automatic set_in(int d, logic r, logic w, logic [3:0] m, logic [31:0] a, logic [31:0] s);
    if (d == 0) begin
      req0 = r; we0 = w; msk0 = m; adr0 = a; sd0 = s;
    end else begin
      req1 = r; we1 = w; msk1 = m; adr1 = a; sd1 = s;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mstore(int k, logic [3:0] m, logic [31:0] s);
    logic [31:0] w;
    w = mdl.exists(k) ? mdl[k] : 32'h0;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = s[8*b +: 8];
    mdl[k] = w;
  endtask

  // One complete access: checks latency, single-cycle pulse and load_data
  task automatic access(int d, logic w, logic [3:0] m, logic [31:0] a, logic [31:0] s,
                        bit have_exp, logic [31:0] exp_in, string nm);
    logic [31:0] prev, exp;
    int k, n;
    prev = get_ld(d);
    k = key_of(d, a);
    if (w) begin
      mstore(k, m, s);
      exp = prev;
    end else begin
      exp = mdl.exists(k) ? mdl[k] : 32'h0;
    end
    if (have_exp) exp = exp_in;
    @(negedge clk);
    set_in(d, 1'b1, w, m, a, s);
    @(posedge clk);
    #1;
    // Scramble everything after the accepting edge; the DUT must not care
    set_in(d, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
    n = 1;
    while (!get_dv(d) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat_of(d)));
    chk({nm, " load_data"}, get_ld(d), exp);
    chk({nm, " busy in RESP"}, 32'(get_bsy(d)), 32'd1);
    @(posedge clk);
    #1;
    chk({nm, " pulse width"}, 32'(get_dv(d)), 32'd0);
    chk({nm, " idle after"}, 32'(get_bsy(d)), 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_word, a;
    int per, pulses, idx;
    bit exp_b, exp_v;

    // ---- Reset values, with request held high during reset ----
    set_in(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    set_in(1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h0);
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dv", 32'(dv0), 32'd0);
    chk("reset busy", 32'(bsy0), 32'd0);
    chk("reset load_data", ld0, 32'h0);
    chk("reset4 busy", 32'(bsy1), 32'd0);
    chk("reset4 load_data", ld1, 32'h0);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_in(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post-reset busy", 32'(bsy0), 32'd0);
    chk("post-reset dv", 32'(dv0), 32'd0);

    // ---- Table: full/partial/zero-mask stores, aliasing, low-bit ignore ----
    tbl[0] = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_AB00, 32'h0};
    tbl[3] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_ABEF};
    tbl[4] = '{1'b1, 4'h0, 32'h0000_0010, 32'h1234_5678, 32'h0};
    tbl[5] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_ABEF};
    tbl[6] = '{1'b1, 4'hF, 32'h0000_1010, 32'h1122_3344, 32'h0};
    tbl[7] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h1122_3344};
    tbl[8] = '{1'b1, 4'h1, 32'h0000_0013, 32'hA5A5_A5A5, 32'h0};
    tbl[9] = '{1'b0, 4'hF, 32'hF000_0012, 32'h0,         32'h1122_33A5};
    for (int i = 0; i < 10; i++) begin
      access(0, tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].s, !tbl[i].w, tbl[i].exp,
             $sformatf("vec%0d", i));
    end

    // ---- Held request: one completion per accept, re-accept right after RESP ----
    per = lat_of(0) + 1;
    exp_word = mdl[key_of(0, 32'h10)];
    pulses = 0;
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(posedge clk);
    for (int j = 0; j < 2 * per; j++) begin
      #1;
      exp_b = (j % per) != lat_of(0);
      exp_v = (j % per) == lat_of(0) - 1;
      chk($sformatf("held busy j=%0d", j), 32'(bsy0), 32'(exp_b));
      chk($sformatf("held dv j=%0d", j), 32'(dv0), 32'(exp_v));
      if (dv0) begin
        pulses++;
        chk($sformatf("held load_data j=%0d", j), ld0, exp_word);
      end
      if (j == 2 * per - 1) req0 = 1'b0;
      @(posedge clk);
    end
    #1;
    chk("held pulses", 32'(pulses), 32'd2);
    chk("held released busy", 32'(bsy0), 32'd0);

    // ---- Randomised accesses against the reference memory ----
    for (int i = 0; i < 8; i++) access(0, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0, 32'h0, "init");
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 7);
      a = ($urandom & 32'hFFFF_F000) | 32'(idx * 4) | ($urandom & 32'h3);
      access(0, 1'($urandom), 4'($urandom), a, $urandom, 1'b0, 32'h0, $sformatf("rnd%0d", i));
    end

    // ---- Latency 4: reset during BUSY aborts, earlier store persists ----
    access(1, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, "l4 store");
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'hCAFE_F00D, "l4 load");
    mstore(key_of(1, 32'h20), 4'hF, 32'h5566_7788);
    @(negedge clk);
    set_in(1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h5566_7788);
    @(posedge clk);
    #1;
    set_in(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("abort busy k", 32'(bsy1), 32'd1);
    @(posedge clk);
    #1;
    chk("abort busy k+1", 32'(bsy1), 32'd1);
    chk("abort dv k+1", 32'(dv1), 32'd0);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    #1;
    chk("abort async busy", 32'(bsy1), 32'd0);
    chk("abort async dv", 32'(dv1), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (dv1) pulses++;
    end
    rst1 = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (dv1) pulses++;
    end
    chk("abort no dv", 32'(pulses), 32'd0);
    chk("abort idle", 32'(bsy1), 32'd0);
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'h5566_7788, "l4 after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
